lab2q_sysid_checker: RTL and testbench

- Avalon-MM master that reads the system-ID slave's two words: address 0 is the ID and address 1 is the timestamp.
- Compares both words against parameterised expected values and reports done, pass/fail and timeout status to software-visible logic or LEDs.
- Sits on the same clock domain as the sysid control slave, connected through the interconnect.
- Exists to catch bitstream/software mismatches at boot.

---
 rtl/lab2q_sysid_checker.sv | 203 ++++++++++++++++++++
 tb/tb_lab2q_sysid_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lab2q_sysid_checker.sv
// lab2q_sysid_checker
// Boot-time sanity check of the system-ID slave. Reads word 0 (ID) and
// word 1 (timestamp) over Avalon-MM, compares each against the values the
// bitstream was built with, and reports sticky done/pass/timeout status.
//
// Ports
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   start            single-cycle pulse requesting a check (ignored while busy)
//   avm_address      word address to sysid slave (0 = ID, 1 = timestamp)
//   avm_read         Avalon read strobe
//   avm_waitrequest  slave stall
//   avm_readdata     read data, valid when avm_read=1 and avm_waitrequest=0
//   busy             check in progress
//   done             sticky: check finished (pass, fail or timeout)
//   pass             sticky: both words matched, no timeout
//   id_ok / ts_ok    per-word match flags (0 for a word never accepted)
//   timeout          a read stalled for TIMEOUT_CYCLES cycles
//   id_word/ts_word  last captured words
//
// state  | meaning
// IDLE   | waiting for start (or the one automatic launch after reset)
// RD_ID  | read strobe up at address 0
// RD_TS  | read strobe up at address 1
// FIN    | check finished, status held until relaunch

module lab2q_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd1,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1432487389,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_word,
   output logic [31:0] ts_word
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_ID = 2'd1,
      RD_TS = 2'd2,
      FIN   = 2'd3
   } state_t;

   // Last stall cycle before abort: counter holds (stalls seen - 1).
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        auto_q, auto_d;
   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_word_q, id_word_d;
   logic [31:0] ts_word_q, ts_word_d;

   logic        ts_match;
   assign ts_match = (avm_readdata == EXPECTED_TIMESTAMP);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      auto_d    = 1'b0;          // automatic launch is offered for one cycle only
      read_d    = read_q;
      addr_d    = addr_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      id_ok_d   = id_ok_q;
      ts_ok_d   = ts_ok_q;
      timeout_d = timeout_q;
      id_word_d = id_word_q;
      ts_word_d = ts_word_q;

      case (state_q)
         IDLE, FIN: begin
            if (start || (auto_q && state_q == IDLE)) begin
               state_d   = RD_ID;
               cnt_d     = 16'd0;
               read_d    = 1'b1;
               addr_d    = 1'b0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
            end
         end

         RD_ID: begin
            if (!avm_waitrequest) begin
               state_d   = RD_TS;
               cnt_d     = 16'd0;
               addr_d    = 1'b1;
               id_word_d = avm_readdata;
               id_ok_d   = (avm_readdata == EXPECTED_ID);
            end else if (cnt_q == TMO_LAST) begin
               state_d   = FIN;
               read_d    = 1'b0;
               addr_d    = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               pass_d    = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         RD_TS: begin
            if (!avm_waitrequest) begin
               state_d   = FIN;
               read_d    = 1'b0;
               addr_d    = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               ts_word_d = avm_readdata;
               ts_ok_d   = ts_match;
               pass_d    = id_ok_q & ts_match;
            end else if (cnt_q == TMO_LAST) begin
               state_d   = FIN;
               read_d    = 1'b0;
               addr_d    = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               pass_d    = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end

         default: begin
            state_d = IDLE;
            read_d  = 1'b0;
            addr_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cnt_q     <= 16'd0;
         auto_q    <= AUTO_START;
         read_q    <= 1'b0;
         addr_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         id_ok_q   <= 1'b0;
         ts_ok_q   <= 1'b0;
         timeout_q <= 1'b0;
         id_word_q <= 32'd0;
         ts_word_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         auto_q    <= auto_d;
         read_q    <= read_d;
         addr_q    <= addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         id_ok_q   <= id_ok_d;
         ts_ok_q   <= ts_ok_d;
         timeout_q <= timeout_d;
         id_word_q <= id_word_d;
         ts_word_q <= ts_word_d;
      end
   end

   assign avm_read    = read_q;
   assign avm_address = addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;
   assign timeout     = timeout_q;
   assign id_word     = id_word_q;
   assign ts_word     = ts_word_q;

endmodule

// File: tb/tb_lab2q_sysid_checker.sv
// Bench for lab2q_sysid_checker: a stalling sysid slave model plus a
// per-check outcome model (read counts, completion edge, status, words).

module tb_lab2q_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd1;
   localparam logic [31:0] EXP_TS = 32'd1432487389;
   localparam int          TMO    = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        avm_address, avm_read, avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy, done, pass, id_ok, ts_ok, timeout;
   logic [31:0] id_word, ts_word;

   int          n_checks = 0;
   int          n_errors = 0;

   // slave model configuration
   int          stall0 = 0, stall1 = 0;
   logic [31:0] id_val = EXP_ID, ts_val = EXP_TS, junk = 32'hDEAD_BEEF;
   int          cyc = 0;
   logic        prev_read = 1'b0, prev_wr = 1'b0;
   logic        wr = 1'b0;

   // expected captured words (persist across checks until recaptured)
   logic [31:0] m_id_word = 32'd0, m_ts_word = 32'd0;

   lab2q_sysid_checker #(
      .EXPECTED_ID       (EXP_ID),
      .EXPECTED_TIMESTAMP(EXP_TS),
      .TIMEOUT_CYCLES    (TMO),
      .AUTO_START        (1'b1)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .start          (start),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata   (avm_readdata),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .id_ok          (id_ok),
      .ts_ok          (ts_ok),
      .timeout        (timeout),
      .id_word        (id_word),
      .ts_word        (ts_word)
   );

   always #5 clock = ~clock;

   // Slave: stalls each read for stallN cycles, returns junk while stalling.
   always @(negedge clock) begin
      if (avm_read) begin
         if (prev_read && prev_wr) cyc = cyc + 1;
         else                      cyc = 0;
      end else begin
         cyc = 0;
      end
      wr = avm_read && (cyc < (avm_address ? stall1 : stall0));
      prev_read = avm_read;
      prev_wr   = wr;
   end

   assign avm_waitrequest = wr;
   assign avm_readdata    = wr ? junk : (avm_address ? ts_val : id_val);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Called at a negedge. via_start=1 pulses start; otherwise the launch is
   // the automatic one right after reset release.
   task automatic run_and_check(input bit via_start, input int s0, input int s1,
                                input logic [31:0] idv, input logic [31:0] tsv,
                                input bit noise);
      int  edges, r0, r1, addr_bad;
      int  exp_r0, exp_r1, exp_done_edge;
      bit  to0, to1, e_to, e_idok, e_tsok, e_pass, seen_done;
      stall0 = s0;
      stall1 = s1;
      id_val = idv;
      ts_val = tsv;
      junk   = ~idv ^ 32'h5A5A_0001;
      to0    = (s0 >= TMO);
      to1    = !to0 && (s1 >= TMO);
      e_to   = to0 || to1;
      exp_r0 = to0 ? TMO : s0 + 1;
      exp_r1 = to0 ? 0 : (to1 ? TMO : s1 + 1);
      e_idok = !to0 && (idv == EXP_ID);
      e_tsok = !e_to && (tsv == EXP_TS);
      e_pass = e_idok && e_tsok;
      if (!to0)  m_id_word = idv;
      if (!e_to) m_ts_word = tsv;
      exp_done_edge = exp_r0 + exp_r1 + 1;

      if (via_start) start = 1'b1;
      edges = 0; r0 = 0; r1 = 0; addr_bad = 0; seen_done = 1'b0;
      while (!seen_done && edges < 200) begin
         @(negedge clock);
         edges++;
         start = 1'b0;
         if (edges == 1) begin
            chk("launch_busy", 32'(busy), 32'd1);
            chk("launch_read", 32'(avm_read), 32'd1);
            chk("launch_addr", 32'(avm_address), 32'd0);
            chk("launch_done_clr", 32'(done), 32'd0);
            chk("launch_pass_clr", 32'(pass), 32'd0);
         end
         if (avm_read) begin
            if (avm_address) r1++;
            else             r0++;
         end else if (avm_address) begin
            addr_bad++;
         end
         if (done) seen_done = 1'b1;
         else if (noise && busy) start = 1'($urandom_range(0, 1));
      end
      chk("done_seen", 32'(seen_done), 32'd1);
      chk("done_edge", 32'(edges), 32'(exp_done_edge));
      chk("reads_addr0", 32'(r0), 32'(exp_r0));
      chk("reads_addr1", 32'(r1), 32'(exp_r1));
      chk("addr_idle_zero", 32'(addr_bad), 32'd0);
      chk("fin_busy", 32'(busy), 32'd0);
      chk("fin_read", 32'(avm_read), 32'd0);
      chk("pass", 32'(pass), 32'(e_pass));
      chk("id_ok", 32'(id_ok), 32'(e_idok));
      chk("ts_ok", 32'(ts_ok), 32'(e_tsok));
      chk("timeout", 32'(timeout), 32'(e_to));
      chk("id_word", id_word, m_id_word);
      chk("ts_word", ts_word, m_ts_word);

      // status is sticky in FIN until the next launch
      repeat ($urandom_range(0, 3)) @(negedge clock);
      chk("done_sticky", 32'(done), 32'd1);
      chk("pass_sticky", 32'(pass), 32'(e_pass));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_read"}, 32'(avm_read), 32'd0);
      chk({tag, "_addr"}, 32'(avm_address), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_pass"}, 32'(pass), 32'd0);
      chk({tag, "_idok"}, 32'(id_ok), 32'd0);
      chk({tag, "_tsok"}, 32'(ts_ok), 32'd0);
      chk({tag, "_tmo"}, 32'(timeout), 32'd0);
      chk({tag, "_idw"}, id_word, 32'd0);
      chk({tag, "_tsw"}, ts_word, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;

      // automatic launch, matching slave, no stall
      run_and_check(1'b0, 0, 0, EXP_ID, EXP_TS, 1'b0);
      // wrong ID
      run_and_check(1'b1, 0, 0, 32'd2, EXP_TS, 1'b0);
      // three stalls on the ID read
      run_and_check(1'b1, 3, 0, EXP_ID, EXP_TS, 1'b0);
      // stuck on ID read: timeout
      run_and_check(1'b1, 255, 0, EXP_ID, EXP_TS, 1'b0);
      // stuck on timestamp read: ID accepted, then timeout
      run_and_check(1'b1, 1, 255, EXP_ID, EXP_TS, 1'b0);
      // stall one short of the limit on both reads, timestamp off by one bit
      run_and_check(1'b1, TMO - 1, TMO - 1, EXP_ID, EXP_TS ^ 32'h8000_0000, 1'b1);
      // start pulses during the reads are ignored
      run_and_check(1'b1, 0, 2, EXP_ID, EXP_TS, 1'b1);

      for (int i = 0; i < 20; i++) begin
         logic [31:0] idv, tsv;
         idv = ($urandom_range(0, 2) != 0) ? EXP_ID : $urandom;
         tsv = ($urandom_range(0, 2) != 0) ? EXP_TS : $urandom;
         run_and_check(1'b1, $urandom_range(0, 5), $urandom_range(0, 5), idv, tsv, 1'b1);
      end

      // reset asserted in the middle of the timestamp read
      stall0 = 0;
      stall1 = 255;
      start  = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      chk("pre_rst_addr", 32'(avm_address), 32'd1);
      #2 reset_n = 1'b0;
      #1 check_all_zero("midrst");
      @(negedge clock);
      reset_n   = 1'b1;
      m_id_word = 32'd0;
      m_ts_word = 32'd0;
      run_and_check(1'b0, 0, 0, EXP_ID, EXP_TS, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
